// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter
// Description : Machine-mode interrupt controller. Synchronises raw MSI, MTI,
//               MEI and local interrupts, keeps pending state (edge or level
//               per local), picks the highest-priority enabled cause, offers
//               it to trap control through a req/ack handshake and tracks
//               the nesting depth of taken interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
    parameter int                   XLEN        = 32,
    parameter int                   NUM_LOCAL   = 16,
    parameter logic [NUM_LOCAL-1:0] LOCAL_EDGE  = '0,
    parameter int                   SYNC_STAGES = 2,
    parameter int                   MAX_NEST    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           irq_msi,
    input  logic                           irq_mti,
    input  logic                           irq_mei,
    input  logic [NUM_LOCAL-1:0]           irq_local,
    input  logic                           mstatus_mie,
    input  logic [XLEN-1:0]                mie,
    input  logic                           mip_clr_wen,
    input  logic [NUM_LOCAL-1:0]           mip_clr,
    input  logic                           irq_ack,
    input  logic                           mret,
    output logic                           irq_req,
    output logic [XLEN-1:0]                irq_cause,
    output logic [XLEN-1:0]                mip,
    output logic [$clog2(MAX_NEST+1)-1:0]  nest_depth
);

    localparam int c_NRAW    = NUM_LOCAL + 3;
    localparam int c_IDX_W   = $clog2(XLEN);
    localparam int c_DEPTH_W = $clog2(MAX_NEST + 1);
    localparam logic [c_DEPTH_W-1:0] c_MAX_DEPTH = c_DEPTH_W'(MAX_NEST);
    localparam logic [XLEN-1:0]      c_IRQ_FLAG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    // raw bit order inside the synchroniser: {local, mei, mti, msi}
    logic [SYNC_STAGES-1:0][c_NRAW-1:0] r_sync;
    logic [NUM_LOCAL-1:0]               r_sync_d;
    logic [XLEN-1:0]                    r_mip;
    logic [0:0]                         r_state;
    logic [0:0]                         w_state_next;
    logic                               r_irq_req;
    logic [XLEN-1:0]                    r_irq_cause;
    logic [c_IDX_W-1:0]                 r_cause_idx;
    logic [c_DEPTH_W-1:0]               r_depth;

    logic [c_NRAW-1:0]    w_sync;
    logic [NUM_LOCAL-1:0] w_sync_loc;
    logic [NUM_LOCAL-1:0] w_loc_rise;
    logic [NUM_LOCAL-1:0] w_ack_clr;
    logic [NUM_LOCAL-1:0] w_loc_clr;
    logic [NUM_LOCAL-1:0] w_loc_next;
    logic [XLEN-1:0]      w_mip_next;
    logic [XLEN-1:0]      w_enabled;
    logic                 w_any;
    logic [c_IDX_W-1:0]   w_win_idx;
    logic                 w_start;
    logic                 w_ack_take;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_sync_loc = w_sync[c_NRAW-1:3];
    assign w_loc_rise = w_sync_loc & ~r_sync_d;
    assign w_enabled  = r_mip & mie & {XLEN{mstatus_mie}};

    // Synchroniser chain for every raw input plus the previous local sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync[0] <= {irq_local, irq_mei, irq_mti, irq_msi};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_sync_d <= w_sync_loc;
        end
    end

    // Edge-mode locals are cleared by a software write-1-to-clear or by taking that very cause
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < NUM_LOCAL; i++) begin
            w_ack_clr[i] = w_ack_take && (r_cause_idx == c_IDX_W'(16 + i));
        end
    end

    assign w_loc_clr  = ({NUM_LOCAL{mip_clr_wen}} & mip_clr) | w_ack_clr;
    // a new edge wins over a clear landing in the same cycle
    assign w_loc_next = (LOCAL_EDGE & (w_loc_rise | (r_mip[16 +: NUM_LOCAL] & ~w_loc_clr)))
                      | (~LOCAL_EDGE & w_sync_loc);

    // Assemble next pending vector; unimplemented causes stay at zero
    always_comb begin
        w_mip_next                 = '0;
        w_mip_next[3]              = w_sync[0];
        w_mip_next[7]              = w_sync[1];
        w_mip_next[11]             = w_sync[2];
        w_mip_next[16 +: NUM_LOCAL] = w_loc_next;
    end

    // Pending register presented to the CSR file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mip <= '0;
        end else begin
            r_mip <= w_mip_next;
        end
    end

    // Priority pick: later assignments override earlier ones, so lowest priority goes first
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        for (int i = 0; i < NUM_LOCAL; i++) begin
            if (w_enabled[16 + i]) begin
                w_any     = 1'b1;
                w_win_idx = c_IDX_W'(16 + i);
            end
        end
        if (w_enabled[7]) begin
            w_any     = 1'b1;
            w_win_idx = c_IDX_W'(7);
        end
        if (w_enabled[3]) begin
            w_any     = 1'b1;
            w_win_idx = c_IDX_W'(3);
        end
        if (w_enabled[11]) begin
            w_any     = 1'b1;
            w_win_idx = c_IDX_W'(11);
        end
    end

    // Handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake next state: ack beats withdrawal, and a request never restarts in the cycle it ends
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_ack_take   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any && (r_depth < c_MAX_DEPTH)) begin
                    w_start      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (!w_enabled[r_cause_idx]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered request and cause; the cause is frozen while the request is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_req   <= 1'b0;
            r_irq_cause <= '0;
            r_cause_idx <= '0;
        end else begin
            r_irq_req <= (w_state_next == S_REQ);
            if (w_start) begin
                r_irq_cause <= c_IRQ_FLAG | XLEN'(w_win_idx);
                r_cause_idx <= w_win_idx;
            end
        end
    end

    // Nesting depth: ack pushes, mret pops, both together cancel, mret at zero is an exception return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= '0;
        end else if (w_ack_take && !mret && (r_depth != c_MAX_DEPTH)) begin
            r_depth <= r_depth + c_DEPTH_W'(1);
        end else if (mret && !w_ack_take && (r_depth != '0)) begin
            r_depth <= r_depth - c_DEPTH_W'(1);
        end
    end

    assign irq_req    = r_irq_req;
    assign irq_cause  = r_irq_cause;
    assign mip        = r_mip;
    assign nest_depth = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_arbiter
// Description : Self-checking bench for irq_arbiter: directed scenarios with
//               literal expectations followed by randomised traffic, all
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

    localparam int          XLEN   = 32;
    localparam int          NL     = 16;
    localparam logic [15:0] EDGE   = 16'h0204;
    localparam int          SYNC   = 2;
    localparam int          MAXN   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          irq_msi, irq_mti, irq_mei;
    logic [NL-1:0] irq_local;
    logic          mstatus_mie;
    logic [31:0]   mie;
    logic          mip_clr_wen;
    logic [NL-1:0] mip_clr;
    logic          irq_ack, mret;
    logic          irq_req;
    logic [31:0]   irq_cause;
    logic [31:0]   mip;
    logic [1:0]    nest_depth;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    irq_arbiter #(
        .XLEN(XLEN), .NUM_LOCAL(NL), .LOCAL_EDGE(EDGE),
        .SYNC_STAGES(SYNC), .MAX_NEST(MAXN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_mei(irq_mei),
        .irq_local(irq_local), .mstatus_mie(mstatus_mie), .mie(mie),
        .mip_clr_wen(mip_clr_wen), .mip_clr(mip_clr),
        .irq_ack(irq_ack), .mret(mret),
        .irq_req(irq_req), .irq_cause(irq_cause), .mip(mip),
        .nest_depth(nest_depth)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [NL+2:0] m_q[$];      // raw samples in flight through the synchroniser
    logic [NL-1:0] m_prev_loc;
    logic [31:0]   m_mip;
    bit            m_busy;
    int            m_code;
    logic [31:0]   m_cause;
    int            m_depth;

    function automatic int pick(input logic [31:0] en);
        int order[NL+3];
        order[0] = 11; order[1] = 3; order[2] = 7;
        for (int k = 0; k < NL; k++) order[3+k] = 16 + NL - 1 - k;
        for (int k = 0; k < NL + 3; k++) if (en[order[k]]) return order[k];
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q = {};
            for (int k = 0; k < SYNC; k++) m_q.push_back('0);
            m_prev_loc = '0; m_mip = '0; m_busy = 0; m_code = 0;
            m_cause = '0; m_depth = 0;
        end else begin
            logic [NL+2:0] s;
            logic [31:0]   en, nm;
            bit            took;
            s    = m_q[0];
            en   = m_mip & mie & {32{mstatus_mie}};
            took = m_busy && irq_ack;
            nm   = '0;
            nm[3] = s[0]; nm[7] = s[1]; nm[11] = s[2];
            for (int i = 0; i < NL; i++) begin
                bit li, clr;
                li  = s[3+i];
                clr = (mip_clr_wen && mip_clr[i]) || (took && m_code == 16 + i);
                if (EDGE[i]) nm[16+i] = (li && !m_prev_loc[i]) ? 1'b1 : (clr ? 1'b0 : m_mip[16+i]);
                else         nm[16+i] = li;
            end
            if (!m_busy) begin
                if (en != 0 && m_depth < MAXN) begin
                    m_busy  = 1;
                    m_code  = pick(en);
                    m_cause = 32'h8000_0000 | 32'(m_code);
                end
            end else if (irq_ack || !en[m_code]) begin
                m_busy = 0;
            end
            if (took && !mret)                   m_depth++;
            else if (mret && !took && m_depth>0) m_depth--;
            m_mip      = nm;
            m_prev_loc = s[NL+2:3];
            void'(m_q.pop_front());
            m_q.push_back({irq_local, irq_mei, irq_mti, irq_msi});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req",   32'(irq_req),    32'(m_busy));
            chk("cause", irq_cause,       m_cause);
            chk("mip",   mip,             m_mip);
            chk("depth", 32'(nest_depth), 32'(m_depth));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_req(input int budget);
        for (int k = 0; k < budget && !irq_req; k++) tick();
        chk("wait_req", 32'(irq_req), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; irq_msi = 0; irq_mti = 0; irq_mei = 0; irq_local = '0;
        mstatus_mie = 1; mie = 32'h888; mip_clr_wen = 0; mip_clr = '0;
        irq_ack = 0; mret = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_cause", irq_cause, 32'd0);
        chk("rst_mip", mip, 32'd0);
        chk("rst_depth", 32'(nest_depth), 32'd0);
        tick_n(2);

        // timer latency, ack, mret
        irq_mti = 1;
        tick_n(2);
        chk("mti_mip_e2", mip, 32'h0);
        tick();
        chk("mti_mip_e3", mip, 32'h80);
        chk("mti_req_e3", 32'(irq_req), 32'd0);
        tick();
        chk("mti_req_e4", 32'(irq_req), 32'd1);
        chk("mti_cause", irq_cause, 32'h8000_0007);
        chk("model_cause7", m_cause, 32'h8000_0007);
        irq_ack = 1;
        tick();
        chk("ack_req", 32'(irq_req), 32'd0);
        chk("ack_depth", 32'(nest_depth), 32'd1);
        irq_ack = 0; irq_mti = 0; mret = 1;
        tick();
        mret = 0;
        chk("mret_depth", 32'(nest_depth), 32'd0);
        tick_n(8);

        // simultaneous arrivals, then MAX_NEST hold-off
        irq_msi = 1; irq_mti = 1; irq_mei = 1;
        tick_n(4);
        chk("mei_cause", irq_cause, 32'h8000_000B);
        chk("model_causeB", m_cause, 32'h8000_000B);
        irq_mei = 0;
        tick_n(2);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        chk("ack2_depth", 32'(nest_depth), 32'd1);
        tick();
        chk("msi_req", 32'(irq_req), 32'd1);
        chk("msi_cause", irq_cause, 32'h8000_0003);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("maxnest_noreq", 32'(irq_req), 32'd0);
        end
        chk("maxnest_depth", 32'(nest_depth), 32'd2);
        chk("model_depth2", 32'(m_depth), 32'd2);
        mret = 1;
        tick();
        mret = 0;
        chk("pop_depth", 32'(nest_depth), 32'd1);
        tick();
        chk("rereq", 32'(irq_req), 32'd1);
        chk("rereq_cause", irq_cause, 32'h8000_0003);

        // mie change withdraws, then mstatus_mie withdraw on cause 7
        mie = 32'h80;
        tick();
        chk("mie_withdraw", 32'(irq_req), 32'd0);
        wait_req(4);
        chk("cause7_again", irq_cause, 32'h8000_0007);
        mstatus_mie = 0;
        tick();
        chk("gie_withdraw", 32'(irq_req), 32'd0);
        chk("gie_depth", 32'(nest_depth), 32'd1);
        irq_msi = 0; irq_mti = 0;
        tick_n(6);
        mstatus_mie = 1; mret = 1;
        tick();
        mret = 0;
        chk("clean_depth", 32'(nest_depth), 32'd0);
        tick_n(3);

        // edge-captured local 2
        mie = 32'h0004_0000;
        irq_local[2] = 1;
        tick();
        irq_local[2] = 0;
        wait_req(8);
        chk("edge_mip", mip, 32'h0004_0000);
        chk("edge_cause", irq_cause, 32'h8000_0012);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        chk("edge_ack_mip", mip, 32'h0);
        chk("edge_ack_req", 32'(irq_req), 32'd0);
        mret = 1;
        tick();
        mret = 0;
        irq_local[2] = 1;
        tick();
        irq_local[2] = 0;
        wait_req(8);
        mip_clr_wen = 1; mip_clr = 16'h0004;
        tick();
        mip_clr_wen = 0; mip_clr = '0;
        chk("w1c_mip", mip, 32'h0);
        chk("w1c_req_hold", 32'(irq_req), 32'd1);
        tick();
        chk("w1c_withdraw", 32'(irq_req), 32'd0);
        chk("w1c_depth", 32'(nest_depth), 32'd0);
        tick_n(2);

        // asynchronous reset in REQ
        mie = 32'h80; irq_mti = 1;
        wait_req(8);
        irq_ack = 1;
        tick();
        irq_ack = 0;
        wait_req(4);
        #2 rst_n = 0;
        #1;
        chk("arst_req", 32'(irq_req), 32'd0);
        chk("arst_mip", mip, 32'd0);
        chk("arst_depth", 32'(nest_depth), 32'd0);
        chk("arst_cause", irq_cause, 32'd0);
        irq_mti = 0;
        tick_n(2);
        rst_n = 1;
        tick_n(2);

        // randomised traffic
        mie = 32'hFFFF_FFFF;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                case ($urandom_range(0, 3))
                    0: mie = 32'hFFFF_FFFF;
                    1: mie = $urandom;
                    2: mie = 32'h0000_0888;
                    default: mie = 32'hFFFF_0000;
                endcase
            end
            if ($urandom_range(0, 7) == 0) irq_msi = ~irq_msi;
            if ($urandom_range(0, 7) == 0) irq_mti = ~irq_mti;
            if ($urandom_range(0, 7) == 0) irq_mei = ~irq_mei;
            irq_local   = irq_local ^ NL'($urandom & $urandom & $urandom);
            irq_ack     = ($urandom_range(0, 2) == 0);
            mret        = ($urandom_range(0, 5) == 0);
            mip_clr_wen = ($urandom_range(0, 5) == 0);
            mip_clr     = NL'($urandom);
            mstatus_mie = ($urandom_range(0, 19) != 0);
            tick();
        end
        irq_ack = 0; mret = 0; mip_clr_wen = 0;
        tick_n(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Parametrised machine-mode interrupt controller that sits between the raw interrupt sources and the trap control logic in the core.
- Synchronises MSI, MTI, MEI and NUM_LOCAL platform-local interrupts, keeps the pending state, and applies per-channel edge/level capture.
- Selects the highest-priority enabled cause and presents it to the pipeline through a req/ack handshake.
- Tracks interrupt nesting depth, so a handler that re-enables MIE can be pre-empted up to MAX_NEST levels.

Parameters:
XLEN, 32, data width; width of mie, mip and irq_cause.
NUM_LOCAL, 16, number of local interrupts (1..XLEN-16); local i has cause code 16+i.
LOCAL_EDGE, all zeros (NUM_LOCAL bits), per-local capture mode: 1 = rising-edge captured and sticky, 0 = level.
SYNC_STAGES, 2, synchroniser flops per raw interrupt input (minimum 2).
MAX_NEST, 4, maximum number of simultaneously active (acked, not yet returned) interrupts.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
irq_msi  in  1  machine software interrupt, raw, asynchronous
irq_mti  in  1  machine timer interrupt, raw, asynchronous
irq_mei  in  1  machine external interrupt, raw, asynchronous
irq_local  in  NUM_LOCAL  local interrupts, raw, asynchronous
mstatus_mie  in  1  global interrupt enable from the CSR file
mie  in  XLEN  per-cause enable; bits 3, 7, 11 and 16+i are used
mip_clr_wen  in  1  CSR write-1-to-clear strobe for edge-mode local pending bits
mip_clr  in  NUM_LOCAL  clear mask, qualified by mip_clr_wen
irq_ack  in  1  pipeline has taken the trap (WB not stalled, next instruction valid)
mret  in  1  trap return retired
irq_req  out  1  interrupt request to trap control
irq_cause  out  XLEN  mcause value: bit XLEN-1 = 1, low bits = cause code
mip  out  XLEN  pending bits to the CSR file
nest_depth  out  $clog2(MAX_NEST+1)  current nesting level

Behaviour:
- Reset (asynchronous on rst_n low) clears everything: synchronisers, pending bits, mip, irq_req, irq_cause, nest_depth, and the FSM returns to IDLE. Reset applies mid-handshake with no residual request.
- Synchronisers: each raw input passes through SYNC_STAGES flops, giving sync_x.
- mip is registered:
  - MSIP, MTIP, MEIP and level-mode locals follow sync_x with 1 cycle of latency.
  - Edge-mode local i sets on sync_x & ~sync_x_d.
  - Edge-mode local i clears on (mip_clr_wen & mip_clr[i]), or on irq_ack while irq_cause selects local i.
  - If a set and a clear hit the same cycle, the set wins.
  - mip_clr has no effect on level-mode bits.
  - Unused mip bits read 0.
- enabled = mip & mie & {XLEN{mstatus_mie}}.
- Priority, highest first: MEI(11), MSI(3), MTI(7), then local NUM_LOCAL-1 down to local 0.
- FSM state IDLE:
  - irq_req = 0.
  - If any bit of enabled is set and nest_depth < MAX_NEST: latch the winning cause into irq_cause, move to REQ, and assert irq_req on the next edge.
- FSM state REQ:
  - irq_req = 1 and irq_cause is held stable. A later higher-priority arrival does not retarget the request.
  - If irq_ack = 1: nest_depth increments, state returns to IDLE, and irq_req = 0 from the next cycle.
  - If irq_ack = 0 and the latched cause is no longer enabled (pending dropped, or mie/mstatus_mie cleared): withdraw the request; irq_req = 0 next cycle and state returns to IDLE.
  - irq_ack takes priority over withdrawal in the same cycle.
- irq_ack outside REQ is ignored.
- nest_depth counter:
  - mret decrements it; mret at depth 0 (exception return) leaves it at 0.
  - irq_ack and mret in the same cycle leave depth unchanged.
  - Depth never exceeds MAX_NEST. At MAX_NEST no new request is issued, even if enabled.
- After a withdrawal or an ack, a new request is not raised in that same cycle; the earliest re-request is 1 cycle after returning to IDLE.
- Latency from raw input rising to irq_req high: SYNC_STAGES+2 clock edges.

Test Plan:
- Reset with mie=0x888, mstatus_mie=1. Raise irq_mti -> mip[7]=1 at edge 3 and irq_req=1 at edge 4 with irq_cause=0x80000007. irq_ack -> irq_req=0 next cycle and nest_depth=1. mret -> nest_depth=0.
- Raise irq_msi, irq_mti and irq_mei in the same cycle -> irq_cause=0x8000000B. After ack with irq_mei dropped -> next irq_cause=0x80000003.
- LOCAL_EDGE[2]=1, mie[18]=1. Pulse irq_local[2] for 1 cycle -> mip[18] stays 1 and irq_cause=0x80000012. irq_ack -> mip[18]=0. Repeat the pulse, then mip_clr_wen with mip_clr=0x4 before the ack -> irq_req withdrawn.
- In REQ with cause 7, drop mstatus_mie without ack -> irq_req=0 next cycle, state IDLE, nest_depth unchanged.
- MAX_NEST=2, mstatus_mie held 1, two acks -> nest_depth=2 and further pending causes raise no irq_req until an mret returns depth to 1.
- Assert rst_n=0 asynchronously while in REQ -> irq_req, mip and nest_depth are 0 immediately, with no clock edge needed.
